// File: rtl/psum_requant.sv
// psum_requant: accumulates groups of signed 32-bit partial sums and
// requantizes each group total to int8 (multiply, rounding shift, zero-point
// add, optional ReLU, saturation). Results leave through a 2-entry FIFO.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   psum_in, psum_valid      partial-sum stream from the PE (no back-pressure)
//   cfg_len                  terms per group (0 treated as 1), latched on first term
//   cfg_mult/shift/zp/relu   requant config, latched with the final term
//   out_data, out_valid,
//   out_ready                int8 result stream (ready/valid)
//   busy                     group partially accumulated or result in flight
//   acc_sat                  sticky: accumulator clamped
//   ovf                      sticky: result dropped on a full FIFO
module psum_requant #(
    parameter int CNT_W      = 8,
    parameter int MULT_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [31:0]       psum_in,
    input  logic                     psum_valid,
    input  logic [CNT_W-1:0]         cfg_len,
    input  logic [MULT_W-1:0]        cfg_mult,
    input  logic [4:0]               cfg_shift,
    input  logic signed [7:0]        cfg_zp,
    input  logic                     cfg_relu,
    output logic signed [7:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy,
    output logic                     acc_sat,
    output logic                     ovf
);

    function automatic logic signed [31:0] sat32(input logic signed [32:0] s);
        if (s[32] != s[31])
            return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return s[31:0];
    endfunction

    function automatic logic signed [7:0] sat8(input logic signed [49:0] r);
        if (r > 50'sd127)
            return 8'sd127;
        if (r < -50'sd128)
            return -8'sd128;
        return r[7:0];
    endfunction

    // Product is at most 2^47 in magnitude; 50 bits leaves room for the
    // rounding constant and the zero point without wrap.
    function automatic logic signed [7:0] requant(input logic signed [47:0] p,
                                                  input logic [4:0]         sh,
                                                  input logic signed [7:0]  zp,
                                                  input logic               relu);
        logic signed [49:0] t;
        logic signed [49:0] zpx;
        logic signed [49:0] one;
        one = 50'sd1;
        zpx = 50'(zp);
        t   = 50'(p);
        if (sh != 5'd0)
            t = t + (one <<< (sh - 5'd1));
        t = t >>> sh;
        t = t + zpx;
        if (relu && (t < zpx))
            t = zpx;
        return sat8(t);
    endfunction

    // Accumulator control
    logic [CNT_W-1:0]   cnt, len_q, len_eff;
    logic signed [31:0] acc, acc_next;
    logic signed [32:0] sum33;
    logic               first, last, clamp;

    always_comb begin
        first    = (cnt == '0);
        len_eff  = len_q;
        if (first)
            len_eff = (cfg_len == '0) ? CNT_W'(1) : cfg_len;
        last     = (cnt == len_eff - CNT_W'(1));
        sum33    = {acc[31], acc} + {psum_in[31], psum_in};
        clamp    = ~first & (sum33[32] ^ sum33[31]);
        acc_next = first ? psum_in : sat32(sum33);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            len_q   <= '0;
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (psum_valid) begin
            acc     <= acc_next;
            acc_sat <= acc_sat | clamp;
            if (first)
                len_q <= len_eff;
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

    // Stage p1: registered group sum and its config
    logic                    vld_p1, vld_p2;
    logic signed [31:0]      sum_p1;
    logic [MULT_W-1:0]       mult_p1;
    logic [4:0]              shift_p1, shift_p2;
    logic signed [7:0]       zp_p1, zp_p2;
    logic                    relu_p1, relu_p2;
    logic signed [47:0]      prod_p2;

    always_ff @(posedge clk) begin
        if (psum_valid && last) begin
            sum_p1   <= acc_next;
            mult_p1  <= cfg_mult;
            shift_p1 <= cfg_shift;
            zp_p1    <= cfg_zp;
            relu_p1  <= cfg_relu;
        end
    end

    // Stage p2: registered product
    always_ff @(posedge clk) begin
        if (vld_p1) begin
            prod_p2  <= 48'(sum_p1) * 48'($signed({1'b0, mult_p1}));
            shift_p2 <= shift_p1;
            zp_p2    <= zp_p1;
            relu_p2  <= relu_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= psum_valid & last;
            vld_p2 <= vld_p1;
        end
    end

    // Output FIFO: a same-edge pop frees the slot the push lands in.
    logic signed [7:0] mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        count;
    logic              push, pop, full, push_ok;
    logic signed [7:0] res_p2;

    always_comb begin
        res_p2  = requant(prod_p2, shift_p2, zp_p2, relu_p2);
        push    = vld_p2;
        pop     = out_valid & out_ready;
        full    = (count == 2'(FIFO_DEPTH));
        push_ok = push & (~full | pop);
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= res_p2;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            if (push_ok && !pop)
                count <= count + 2'd1;
            else if (pop && !push_ok)
                count <= count - 2'd1;
            if (push && !push_ok)
                ovf <= 1'b1;
        end
    end

    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : 8'sd0;
    assign busy      = (cnt != '0) | vld_p1 | vld_p2;

endmodule

// File: tb/tb_psum_requant.sv
module tb_psum_requant;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [31:0] psum_in;
    logic               psum_valid;
    logic [7:0]         cfg_len;
    logic [15:0]        cfg_mult;
    logic [4:0]         cfg_shift;
    logic signed [7:0]  cfg_zp;
    logic               cfg_relu;
    logic signed [7:0]  out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               acc_sat;
    logic               ovf;

    int checks = 0;
    int errors = 0;
    logic signed [7:0] exp_q[$];

    psum_requant dut (
        .clk(clk), .rst(rst),
        .psum_in(psum_in), .psum_valid(psum_valid),
        .cfg_len(cfg_len), .cfg_mult(cfg_mult), .cfg_shift(cfg_shift),
        .cfg_zp(cfg_zp), .cfg_relu(cfg_relu),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .acc_sat(acc_sat), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: every accepted output is compared to the queue head.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0d, required none", out_data);
            end else begin
                logic signed [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL out_data: got %0d, required %0d", out_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic set_cfg(input logic [7:0] len, input logic [15:0] mult,
                           input logic [4:0] sh, input logic signed [7:0] zp,
                           input logic relu);
        cfg_len = len; cfg_mult = mult; cfg_shift = sh; cfg_zp = zp; cfg_relu = relu;
    endtask

    task automatic send(input logic signed [31:0] v);
        psum_in    = v;
        psum_valid = 1'b1;
        @(posedge clk); #1;
        psum_valid = 1'b0;
    endtask

    task automatic single(input logic signed [31:0] v, input logic signed [7:0] e);
        send(v);
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || busy || out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_drain_done"}, 32'(n < 40), 32'd1);
        chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b0; psum_in = '0; psum_valid = 1'b0; out_ready = 1'b1;
        set_cfg(8'd4, 16'd1, 5'd0, 8'sd0, 1'b0);
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", {30'd0, acc_sat, ovf}, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;

        // Basic group of 4 with latency check
        send(10); send(20); send(30); send(40);
        exp_q.push_back(8'sd100);
        chk("lat_n", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_n1", 32'(out_valid), 0);
        @(posedge clk); #1;
        chk("lat_n2", 32'(out_valid), 1);
        drain("basic");
        chk("basic_busy", 32'(busy), 0);
        chk("basic_acc_sat", 32'(acc_sat), 0);

        // Output saturation and accumulator clamp
        set_cfg(8'd1, 16'd1, 5'd0, 8'sd0, 1'b0);
        single(1000, 8'sd127);
        single(-1000, -8'sd128);
        drain("sat8");
        set_cfg(8'd2, 16'd1, 5'd0, 8'sd0, 1'b0);
        send(32'sh7FFF_FFF0); send(32'sh7FFF_FFF0);
        exp_q.push_back(8'sd127);
        drain("sat32");
        chk("acc_sat_set", 32'(acc_sat), 1);

        // Rounding shift
        set_cfg(8'd1, 16'd1, 5'd1, 8'sd0, 1'b0);
        single(3, 8'sd2);
        single(-3, -8'sd1);
        set_cfg(8'd1, 16'd3, 5'd2, 8'sd0, 1'b0);
        single(5, 8'sd4);
        drain("round");

        // ReLU around a negative zero point
        set_cfg(8'd1, 16'd1, 5'd0, -8'sd5, 1'b0);
        single(-50, -8'sd55);
        set_cfg(8'd1, 16'd1, 5'd0, -8'sd5, 1'b1);
        single(-50, -8'sd5);
        drain("relu");
        chk("ovf_clear", 32'(ovf), 0);

        // Back-pressure: third result dropped
        set_cfg(8'd1, 16'd1, 5'd0, 8'sd0, 1'b0);
        out_ready = 1'b0;
        single(1, 8'sd1); single(2, 8'sd2); send(3);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_ovf", 32'(ovf), 1);
        chk("bp_head", 32'(out_data), 32'(8'sd1));
        drain("bp");
        chk("bp_empty", 32'(out_valid), 0);

        // Same-edge pop on the third push: nothing dropped
        out_ready = 1'b0;
        single(1, 8'sd1); single(2, 8'sd2); single(3, 8'sd3);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain("bp_pop");
        chk("bp_pop_empty", 32'(out_valid), 0);

        // Reset mid-group discards everything and clears flags
        set_cfg(8'd4, 16'd1, 5'd0, 8'sd0, 1'b0);
        send(7); send(7);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_flags", {30'd0, acc_sat, ovf}, 0);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        send(5); send(5); send(5); send(5);
        exp_q.push_back(8'sd20);
        drain("post_rst");
        chk("post_rst_flags", {30'd0, acc_sat, ovf}, 0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
